// File: rtl/vcop_pkg.sv
// Shared types and constants for the vector coprocessor issue controller.
// Register width is fixed at VLEN bits; element counts follow from SEW and LMUL grouping.
package vcop_pkg;

  typedef enum logic [2:0] {
    OP_VXOR     = 3'd0,
    OP_VMACC    = 3'd1,
    OP_VREDSUM  = 3'd2,
    OP_VSLIDEUP = 3'd3,
    OP_VRGATHER = 3'd4
  } vop_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHK,
    ST_READ,
    ST_EXEC,
    ST_WB,
    ST_DONE
  } state_e;

  localparam int unsigned BEATS_LMUL1 = 4;
  localparam int unsigned VLEN        = 128;

  localparam int unsigned ELEMS_E8_M1  = VLEN / 8;
  localparam int unsigned ELEMS_E8_M4  = ELEMS_E8_M1 * BEATS_LMUL1;
  localparam int unsigned ELEMS_E32_M1 = VLEN / 32;
  localparam int unsigned ELEMS_E32_M4 = ELEMS_E32_M1 * BEATS_LMUL1;

  function automatic logic [6:0] elem_count(input logic sew, input logic lmul);
    logic [6:0] n;
    case ({sew, lmul})
      2'b00:   n = 7'(ELEMS_E8_M1);
      2'b01:   n = 7'(ELEMS_E8_M4);
      2'b10:   n = 7'(ELEMS_E32_M1);
      default: n = 7'(ELEMS_E32_M4);
    endcase
    return n;
  endfunction

endpackage

// File: rtl/vcop_legal_chk.sv
// Combinational legality check for one latched vector instruction.
// Flags bad opcodes, misaligned LMUL groups, vd/vs2 overlap for permutes and out-of-range slide offsets.
module vcop_legal_chk
  import vcop_pkg::*;
#(
  parameter int unsigned OP_W = 3
) (
  input  logic [OP_W-1:0] op,
  input  logic [4:0]      vd,
  input  logic [4:0]      vs1,
  input  logic [4:0]      vs2,
  input  logic [4:0]      uimm,
  input  logic            lmul,
  input  logic            sew,
  output logic            illegal
);

  logic       op_bad;
  logic       is_redsum;
  logic       is_permute;
  logic       is_slide;
  logic       mis_vd_vs2;
  logic       mis_vs1;
  logic       overlap;
  logic       slide_oob;
  logic [5:0] span;
  logic [5:0] vd_w;
  logic [5:0] vs2_w;

  always_comb begin
    op_bad     = (int'(op) > int'(OP_VRGATHER));
    is_redsum  = (op == OP_W'(OP_VREDSUM));
    is_slide   = (op == OP_W'(OP_VSLIDEUP));
    is_permute = is_slide || (op == OP_W'(OP_VRGATHER));

    mis_vd_vs2 = lmul && ((vd[1:0] != 2'b00) || (vs2[1:0] != 2'b00));
    mis_vs1    = lmul && !is_redsum && (vs1[1:0] != 2'b00);

    // Inclusive register ranges; widened so vd+3 cannot wrap before comparing.
    span    = lmul ? 6'(BEATS_LMUL1 - 1) : 6'd0;
    vd_w    = {1'b0, vd};
    vs2_w   = {1'b0, vs2};
    overlap = is_permute && (vd_w <= vs2_w + span) && (vs2_w <= vd_w + span);

    slide_oob = is_slide && ({2'b00, uimm} >= elem_count(sew, lmul));

    illegal = op_bad || mis_vd_vs2 || mis_vs1 || overlap || slide_oob;
  end

endmodule

// File: rtl/vcop_issue_ctrl.sv
// Single-issue sequencer for the vector coprocessor datapath: accept, check, then beat-by-beat READ/EXEC/WB.
// Optional build macro VCOP_PERF_CNT_EN adds perf_cycles/perf_insns counter ports.
module vcop_issue_ctrl
  import vcop_pkg::*;
#(
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned MACC_LAT = 2,
  parameter int unsigned OP_W     = 3
) (
  input  logic            vsi_clk,
  input  logic            vsi_rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [OP_W-1:0] cmd_op,
  input  logic [4:0]      cmd_vd,
  input  logic [4:0]      cmd_vs1,
  input  logic [4:0]      cmd_vs2,
  input  logic [4:0]      cmd_uimm,
  input  logic            cmd_lmul,
  input  logic            cmd_sew,
  output logic            exec_en,
  output logic            is_vxor,
  output logic            is_vmacc,
  output logic            is_vredsum,
  output logic            is_vslideup,
  output logic            is_vrgather,
  output logic            vsi_lmul,
  output logic            vsi_sew,
  output logic [4:0]      vd_addr,
  output logic [4:0]      vs1_addr,
  output logic [4:0]      vs2_addr,
  output logic [4:0]      uimm,
  output logic [1:0]      beat_idx,
  output logic            rf_we,
  output logic            done,
  output logic            done_err
`ifdef VCOP_PERF_CNT_EN
  ,
  output logic [31:0]     perf_cycles,
  output logic [31:0]     perf_insns
`endif
);

  localparam logic [7:0] RD_LAST   = 8'(RD_LAT - 1);
  localparam logic [7:0] MACC_LAST = 8'(MACC_LAT - 1);

  state_e          state_q;
  state_e          state_d;
  logic [OP_W-1:0] op_q;
  logic [7:0]      cnt_q;
  logic            err_q;
  logic            illegal;
  logic            accept;
  logic            busy;
  logic            grouped;
  logic            last_beat;
  logic            exec_last;

  vcop_legal_chk #(
    .OP_W(OP_W)
  ) u_legal_chk (
    .op      (op_q),
    .vd      (vd_addr),
    .vs1     (vs1_addr),
    .vs2     (vs2_addr),
    .uimm    (uimm),
    .lmul    (vsi_lmul),
    .sew     (vsi_sew),
    .illegal (illegal)
  );

  // vredsum consumes the whole group in one beat, so only other grouped ops step through beats.
  assign grouped   = vsi_lmul && (op_q != OP_W'(OP_VREDSUM));
  assign last_beat = !grouped || (beat_idx == 2'(BEATS_LMUL1 - 1));
  assign exec_last = (op_q == OP_W'(OP_VMACC)) ? (cnt_q == MACC_LAST) : 1'b1;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state_q != ST_IDLE);

  assign is_vxor     = busy && (op_q == OP_W'(OP_VXOR));
  assign is_vmacc    = busy && (op_q == OP_W'(OP_VMACC));
  assign is_vredsum  = busy && (op_q == OP_W'(OP_VREDSUM));
  assign is_vslideup = busy && (op_q == OP_W'(OP_VSLIDEUP));
  assign is_vrgather = busy && (op_q == OP_W'(OP_VRGATHER));

  always_ff @(posedge vsi_clk or negedge vsi_rst_n) begin
    if (!vsi_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    exec_en   = 1'b0;
    rf_we     = 1'b0;
    done      = 1'b0;
    done_err  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Gated by reset so the handshake is quiet while reset is held.
        cmd_ready = vsi_rst_n;
        if (cmd_valid && vsi_rst_n) state_d = ST_CHK;
      end
      ST_CHK: begin
        state_d = illegal ? ST_DONE : ST_READ;
      end
      ST_READ: begin
        if (cnt_q == RD_LAST) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        exec_en = 1'b1;
        if (exec_last) state_d = ST_WB;
      end
      ST_WB: begin
        exec_en = 1'b1;
        rf_we   = 1'b1;
        state_d = last_beat ? ST_DONE : ST_READ;
      end
      ST_DONE: begin
        done     = 1'b1;
        done_err = err_q;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge vsi_clk or negedge vsi_rst_n) begin
    if (!vsi_rst_n) begin
      cnt_q <= '0;
    end else if (state_d != state_q) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  always_ff @(posedge vsi_clk or negedge vsi_rst_n) begin
    if (!vsi_rst_n) begin
      op_q     <= '0;
      vd_addr  <= '0;
      vs1_addr <= '0;
      vs2_addr <= '0;
      uimm     <= '0;
      vsi_lmul <= 1'b0;
      vsi_sew  <= 1'b0;
      beat_idx <= '0;
      err_q    <= 1'b0;
    end else if (accept) begin
      op_q     <= cmd_op;
      vd_addr  <= cmd_vd;
      vs1_addr <= cmd_vs1;
      vs2_addr <= cmd_vs2;
      uimm     <= cmd_uimm;
      vsi_lmul <= cmd_lmul;
      vsi_sew  <= cmd_sew;
      beat_idx <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state_q == ST_CHK) err_q <= illegal;
      // More beats only exist for grouped ops, so every operand steps to the next group register.
      if (state_q == ST_WB && !last_beat) begin
        beat_idx <= beat_idx + 2'd1;
        vd_addr  <= vd_addr + 5'd1;
        vs1_addr <= vs1_addr + 5'd1;
        vs2_addr <= vs2_addr + 5'd1;
      end
    end
  end

`ifdef VCOP_PERF_CNT_EN
  always_ff @(posedge vsi_clk or negedge vsi_rst_n) begin
    if (!vsi_rst_n) begin
      perf_cycles <= '0;
      perf_insns  <= '0;
    end else begin
      if (busy) perf_cycles <= perf_cycles + 32'd1;
      if (done && !done_err) perf_insns <= perf_insns + 32'd1;
    end
  end
`endif

endmodule
